// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared LEGv8 opcode, ALU, state and class encodings
package multicycle_ctrl_pkg;

  localparam int OPCODE_W = 11;

  // Exact 11-bit opcodes; narrower formats are zero-extended in the upper bits
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'h7C0;
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'h7C2;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'h458;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'h658;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'h450;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'h550;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 11'h244;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 11'h344;
  localparam logic [OPCODE_W-1:0] OP_CBZ  = 11'h0B4;
  localparam logic [OPCODE_W-1:0] OP_CBNZ = 11'h0B5;
  localparam logic [OPCODE_W-1:0] OP_B    = 11'h005;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 11'h000;

  // ALU function codes as driven on alu_op
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_PASSB = 3'd4
  } alu_fn_t;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Instruction classes; each class selects one path through the FSM
  typedef enum logic [3:0] {
    C_NOP = 4'd0,
    C_R   = 4'd1,
    C_I   = 4'd2,
    C_LD  = 4'd3,
    C_ST  = 4'd4,
    C_CB  = 4'd5,
    C_CBN = 4'd6,
    C_B   = 4'd7,
    C_ILL = 4'd8
  } op_class_t;

  // Classes that finish with a register-file write
  function automatic logic class_writes_reg(input op_class_t c);
    return (c == C_R) || (c == C_I) || (c == C_LD);
  endfunction

  // Classes that need a data-memory access
  function automatic logic class_uses_mem(input op_class_t c);
    return (c == C_LD) || (c == C_ST);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_op_classify.sv
// rtl/multicycle_ctrl_op_classify.sv - combinational opcode to class and ALU function map
module op_classify
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_t           o_class,
  output alu_fn_t             o_alu_fn
);

  // Exact-match decode; anything unlisted is illegal and leaves the ALU at ADD
  always_comb begin
    o_class  = C_ILL;
    o_alu_fn = ALU_ADD;
    case (i_opcode)
      OP_ADD:  begin o_class = C_R;   o_alu_fn = ALU_ADD;   end
      OP_SUB:  begin o_class = C_R;   o_alu_fn = ALU_SUB;   end
      OP_AND:  begin o_class = C_R;   o_alu_fn = ALU_AND;   end
      OP_ORR:  begin o_class = C_R;   o_alu_fn = ALU_OR;    end
      OP_ADDI: begin o_class = C_I;   o_alu_fn = ALU_ADD;   end
      OP_SUBI: begin o_class = C_I;   o_alu_fn = ALU_SUB;   end
      OP_LDUR: begin o_class = C_LD;  o_alu_fn = ALU_ADD;   end
      OP_STUR: begin o_class = C_ST;  o_alu_fn = ALU_ADD;   end
      OP_CBZ:  begin o_class = C_CB;  o_alu_fn = ALU_PASSB; end
      OP_CBNZ: begin o_class = C_CBN; o_alu_fn = ALU_PASSB; end
      OP_B:    begin o_class = C_B;   o_alu_fn = ALU_ADD;   end
      OP_NOP:  begin o_class = C_NOP; o_alu_fn = ALU_ADD;   end
      default: begin o_class = C_ILL; o_alu_fn = ALU_ADD;   end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle LEGv8 control FSM with req/ack memory handshake
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [10:0]        opcode,
  input  logic               alu_zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               busy,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired
);

  state_t     r_state;
  state_t     w_next_state;
  op_class_t  r_class;
  alu_fn_t    r_alu_fn;
  op_class_t  w_class;
  alu_fn_t    w_alu_fn;
  logic [CNT_W-1:0] r_retired;

  op_classify u_op_classify (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_alu_fn (w_alu_fn)
  );

  // State register; reset drops any in-flight memory request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the instruction class in DECODE so EXEC/MEM/WB see a stable copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class  <= C_NOP;
      r_alu_fn <= ALU_ADD;
    end else if (r_state == S_DECODE) begin
      r_class  <= w_class;
      r_alu_fn <= w_alu_fn;
    end
  end

  // Retired-instruction counter, bumped once per DONE and allowed to wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_state == S_DONE) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state: memory states wait on ack, run is sampled only at boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next_state = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (class_uses_mem(r_class)) begin
          w_next_state = S_MEM;
        end else if (class_writes_reg(r_class)) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_next_state = (r_class == C_LD) ? S_WB : S_DONE;
        end
      end
      S_WB:     w_next_state = S_DONE;
      S_DONE:   w_next_state = run ? S_FETCH : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs from state and class; FETCH strobes and CB pc_write are the only input-qualified ones
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    illegal_op = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op = ALUOP_W'(r_alu_fn);
        case (r_class)
          C_I, C_LD, C_ST: alu_src = 1'b1;
          C_CB: begin
            pc_write = alu_zero;
            pc_src   = 1'b1;
          end
          C_CBN: begin
            pc_write = !alu_zero;
            pc_src   = 1'b1;
          end
          C_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          C_ILL:   illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (r_class == C_ST);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_class == C_LD);
      end
      default: ;
    endcase
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench with per-cycle reference schedule
module tb_multicycle_ctrl;

  localparam int CNT_W   = 32;
  localparam int ALUOP_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic [10:0]        opcode;
  logic               alu_zero;
  logic               mem_ack;
  logic               mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src;
  logic               reg_write, mem_to_reg, alu_src, busy, illegal_op;
  logic [ALUOP_W-1:0] alu_op;
  logic [CNT_W-1:0]   retired;

  multicycle_ctrl #(.CNT_W(CNT_W), .ALUOP_W(ALUOP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .busy       (busy),
    .illegal_op (illegal_op),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, alu_src;
    logic [3:0] alu_op;
    logic       busy, illegal_op;
  } obs_t;

  typedef struct {
    logic        run;
    logic        ack;
    obs_t        exp;
    logic [31:0] ret;
  } cyc_t;

  obs_t        obs;
  cyc_t        sched[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc_no = 0;
  logic [31:0] model_ret = 0;

  assign obs = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src,
                reg_write, mem_to_reg, alu_src, alu_op, busy, illegal_op};

  function automatic obs_t quiet(input logic b);
    obs_t o;
    o = '0;
    o.busy = b;
    return o;
  endfunction

  function automatic void push(input logic r, input logic a, input obs_t e);
    cyc_t c;
    c.run = r;
    c.ack = a;
    c.exp = e;
    c.ret = model_ret;
    sched.push_back(c);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, built from the ISA rules
  task automatic plan_instr(input logic [10:0] op, input int fw, input int mw,
                            input logic z, input logic drop_run);
    obs_t o;
    logic r_t, i_t, ld, st, cbz, cbnz, br, ill;
    logic [3:0] aop;
    logic late_run;
    {r_t, i_t, ld, st, cbz, cbnz, br, ill} = '0;
    aop = 4'd0;
    case (op)
      11'h458: begin r_t = 1; aop = 4'd0; end
      11'h658: begin r_t = 1; aop = 4'd1; end
      11'h450: begin r_t = 1; aop = 4'd2; end
      11'h550: begin r_t = 1; aop = 4'd3; end
      11'h244: begin i_t = 1; aop = 4'd0; end
      11'h344: begin i_t = 1; aop = 4'd1; end
      11'h7C2: ld = 1;
      11'h7C0: st = 1;
      11'h0B4: begin cbz = 1; aop = 4'd4; end
      11'h0B5: begin cbnz = 1; aop = 4'd4; end
      11'h005: br = 1;
      11'h000: ;
      default: ill = 1;
    endcase
    late_run = !drop_run;
    for (int k = 0; k < fw; k++) begin
      o = quiet(1); o.mem_req = 1;
      push(1, 0, o);
    end
    o = quiet(1); o.mem_req = 1; o.ir_write = 1; o.pc_write = 1;
    push(1, 1, o);
    push(1, 1'($urandom), quiet(1));
    o = quiet(1);
    o.alu_op  = aop;
    o.alu_src = i_t | ld | st;
    if (cbz)  begin o.pc_write = z;  o.pc_src = 1; end
    if (cbnz) begin o.pc_write = !z; o.pc_src = 1; end
    if (br)   begin o.pc_write = 1;  o.pc_src = 1; end
    o.illegal_op = ill;
    push(1, 1'($urandom), o);
    if (ld || st) begin
      for (int k = 0; k <= mw; k++) begin
        o = quiet(1); o.mem_req = 1; o.mem_sel = 1; o.mem_we = st;
        push(late_run, (k == mw), o);
      end
    end
    if (r_t || i_t || ld) begin
      o = quiet(1); o.reg_write = 1; o.mem_to_reg = ld;
      push(late_run, 1'($urandom), o);
    end
    push(late_run, 1'($urandom), quiet(1));
    model_ret = model_ret + 1;
  endtask

  // Replay the schedule, driving after the rising edge and checking on the falling edge
  task automatic play();
    cyc_t c;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      run     = c.run;
      mem_ack = c.ack;
      @(negedge clk);
      cyc_no++;
      checks++;
      assert (obs === c.exp) else begin
        errors++;
        $error("FAIL outputs cyc=%0d op=%h observed=%b expected=%b", cyc_no, opcode, obs, c.exp);
      end
      checks++;
      assert (retired === c.ret) else begin
        errors++;
        $error("FAIL retired cyc=%0d observed=%0d expected=%0d", cyc_no, retired, c.ret);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [10:0] op, input int fw, input int mw,
                          input logic z, input logic drop_run);
    plan_instr(op, fw, mw, z, drop_run);
    opcode   = op;
    alu_zero = z;
    play();
  endtask

  logic [10:0] legal_ops [12];

  initial begin
    legal_ops = '{11'h7C0, 11'h7C2, 11'h458, 11'h658, 11'h450, 11'h550,
                  11'h244, 11'h344, 11'h0B4, 11'h0B5, 11'h005, 11'h000};
    rst_n = 0; run = 0; mem_ack = 0; alu_zero = 0; opcode = 11'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (obs === quiet(0)) else begin
      errors++;
      $error("FAIL reset_outputs observed=%b expected=%b", obs, quiet(0));
    end
    checks++;
    assert (retired === 32'd0) else begin
      errors++;
      $error("FAIL reset_retired observed=%0d expected=0", retired);
    end
    @(posedge clk);
    #1;
    rst_n = 1;

    // Directed: one IDLE cycle, then the listed instructions back to back
    push(1, 1'($urandom), quiet(0));
    do_instr(11'h458, 0, 0, 0, 0);
    do_instr(11'h7C2, 0, 3, 0, 0);
    do_instr(11'h0B4, 1, 0, 1, 0);
    do_instr(11'h0B4, 0, 0, 0, 0);
    do_instr(11'h0B5, 0, 0, 1, 0);
    do_instr(11'h0B5, 2, 0, 0, 0);
    do_instr(11'h7FF, 0, 0, 0, 0);
    do_instr(11'h005, 0, 0, 1, 0);
    do_instr(11'h000, 0, 0, 0, 0);
    do_instr(11'h244, 0, 0, 0, 0);
    do_instr(11'h344, 1, 0, 0, 0);
    do_instr(11'h658, 0, 0, 0, 0);
    do_instr(11'h450, 0, 0, 0, 0);
    do_instr(11'h550, 0, 0, 0, 0);
    do_instr(11'h7C0, 0, 0, 0, 0);

    // Random mix of legal and arbitrary opcodes with random wait states
    for (int n = 0; n < 60; n++) begin
      logic [10:0] op;
      if ($urandom_range(0, 4) == 0) op = 11'($urandom);
      else op = legal_ops[$urandom_range(0, 11)];
      do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
    end

    // Store with run dropped while waiting for the data ack, then stay idle
    do_instr(11'h7C0, 0, 3, 0, 1);
    for (int k = 0; k < 4; k++) push(0, 1'($urandom), quiet(0));
    play();

    // Restart, stall in FETCH, then reset mid-request
    push(1, 1'($urandom), quiet(0));
    begin
      obs_t o;
      o = quiet(1); o.mem_req = 1;
      push(1, 0, o);
      push(1, 0, o);
    end
    play();
    #2;
    checks++;
    assert (mem_req === 1'b1) else begin
      errors++;
      $error("FAIL fetch_stall_req observed=%b expected=1", mem_req);
    end
    rst_n = 0;
    #1;
    checks++;
    assert ({mem_req, busy} === 2'b00) else begin
      errors++;
      $error("FAIL async_reset_req_busy observed=%b expected=00", {mem_req, busy});
    end
    checks++;
    assert (retired === 32'd0) else begin
      errors++;
      $error("FAIL async_reset_retired observed=%0d expected=0", retired);
    end
    run = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_ret = 0;
    for (int k = 0; k < 4; k++) push(0, 1'($urandom), quiet(0));
    play();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
